gray_pixel_packer: RTL

Downstream stage of the RGB565 grayscale custom instruction: accepts a stream of 8-bit gray pixels, packs four per 32-bit word, buffers the words in a small FIFO, and lets the CPU drain them through a one-cycle custom-instruction interface. It sits between the grayscale converter output and the processor's custom-instruction bus. The packed words can then be stored to frame memory with one store per four pixels.

---
 rtl/gray_pixel_packer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gray_pixel_packer.sv
// ============================================================================
// gray_pixel_packer - packs 8-bit gray pixels four per 32-bit word into a FIFO
// drained through a one-cycle custom-instruction port.
// Option macro: GRAY_PACKER_BIG_ENDIAN_EN (first pixel lands in [31:24]).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_pixel_packer #(
  parameter logic [7:0] customInstructionId = 8'd102,
  parameter int         FIFO_DEPTH_LOG2     = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pixelValid,
  input  logic [7:0]  pixelData,
  input  logic        frameStart,
  input  logic        start,
  input  logic [7:0]  iseld,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic        wordAvailable
);

  localparam int              DEPTH      = 1 << FIFO_DEPTH_LOG2;
  localparam int              PW         = FIFO_DEPTH_LOG2;
  localparam int              CW         = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
  localparam logic [1:0]      CMD_POP    = 2'd1;
  localparam logic [1:0]      CMD_CLEAR  = 2'd2;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   asm_q, asm_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic [31:0]   result_q, result_d;

  logic          cmd_hit, cmd_pop, cmd_clear;
  logic          fifo_full, fifo_empty;
  logic          pop_fire, push_req, push_fire;
  logic [1:0]    lane_eff, byte_sel;
  logic [31:0]   asm_eff, word_next;
  logic [7:0]    count8;

  logic unused_inputs;
  assign unused_inputs = ^{valueB, valueA[31:2]};

  always_comb begin
    cmd_hit    = start && (iseld == customInstructionId);
    cmd_pop    = cmd_hit && (valueA[1:0] == CMD_POP);
    cmd_clear  = cmd_hit && (valueA[1:0] == CMD_CLEAR);
    fifo_full  = (count_q == FULL_COUNT);
    fifo_empty = (count_q == '0);
    count8     = 8'(count_q);
    pop_fire   = cmd_pop && !fifo_empty;

    // frameStart restarts the word before this cycle's pixel is placed
    lane_eff = frameStart ? 2'd0 : lane_q;
    asm_eff  = frameStart ? 32'h0 : asm_q;
`ifdef GRAY_PACKER_BIG_ENDIAN_EN
    byte_sel = 2'd3 - lane_eff;
`else
    byte_sel = lane_eff;
`endif
    word_next = asm_eff;
    word_next[{byte_sel, 3'b000} +: 8] = pixelData;

    push_req  = pixelValid && (lane_eff == 2'd3) && !cmd_clear;
    push_fire = push_req && (!fifo_full || pop_fire);

    lane_d     = lane_q;
    asm_d      = asm_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (cmd_clear) begin
      lane_d     = 2'd0;
      asm_d      = 32'h0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      lane_d = lane_eff;
      asm_d  = asm_eff;
      if (pixelValid) begin
        lane_d = lane_eff + 2'd1;
        asm_d  = (lane_eff == 2'd3) ? 32'h0 : word_next;
      end
      if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_fire) - CW'(pop_fire);
      if (push_req && !push_fire) overflow_d = 1'b1;
    end

    // Status and pop data reflect the state before this edge's updates
    done_d   = cmd_hit;
    result_d = 32'h0;
    if (cmd_hit && !cmd_pop && !cmd_clear)
      result_d = {14'b0, fifo_full, overflow_q, 6'b0, lane_q, count8};
    else if (pop_fire)
      result_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      lane_q     <= 2'd0;
      asm_q      <= 32'h0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 32'h0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      lane_q     <= lane_d;
      asm_q      <= asm_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clock) begin
    if (!reset && push_fire) mem_q[wr_ptr_q] <= word_next;
  end

  assign done          = done_q;
  assign result        = result_q;
  assign wordAvailable = !fifo_empty;

endmodule

`default_nettype wire
